// File: rtl/fta_bus_pkg.sv
// FTA bus request/response types shared by the request queue and its FIFO.
// Also holds small decode helpers used by the issue sequencer.
package fta_bus_pkg;

    typedef enum logic [2:0] {
        CLASSIC = 3'd0,
        ERC     = 3'd1,
        INCR    = 3'd2,
        EOB     = 3'd7
    } fta_cti_t;

    typedef enum logic [1:0] {
        OKAY = 2'd0,
        ERR  = 2'd1,
        IRQ  = 2'd2,
        RSVD = 2'd3
    } fta_err_t;

    typedef struct packed {
        logic        cyc;
        logic        we;
        fta_cti_t    cti;
        logic [3:0]  pri;
        logic [7:0]  tid;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
    } fta_cmd_request32_t;

    typedef struct packed {
        logic        ack;
        fta_err_t    err;
        logic [3:0]  pri;
        logic [7:0]  tid;
        logic [31:0] adr;
        logic [31:0] dat;
    } fta_cmd_response32_t;

    // Reads and ERC writes expect a response from the bridge; plain writes do not.
    function automatic logic needs_resp(input fta_cmd_request32_t r);
        return (!r.we) || (r.cti == ERC);
    endfunction

endpackage

// File: rtl/fta_req_fifo.sv
// Circular request buffer with registered full/empty flags and occupancy count.
// Pushes while full and pops while empty are ignored.
module fta_req_fifo
    import fta_bus_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  fta_cmd_request32_t       din,
    input  logic                     pop,
    output fta_cmd_request32_t       dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    fta_cmd_request32_t mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic [AW:0]   count_next_s;
    logic          full_r;
    logic          empty_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    // Qualify requests against the current flags and derive the next occupancy.
    always_comb begin
        push_ok_s    = push && !full_r;
        pop_ok_s     = pop && !empty_r;
        count_next_s = count_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_next_s = count_r + (AW+1)'(1);
            2'b01:   count_next_s = count_r - (AW+1)'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Pointers, count and flags; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_next_s;
            full_r  <= (count_next_s == FULL_CNT);
            empty_r <= (count_next_s == (AW+1)'(0));
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign full  = full_r;
    assign empty = empty_r;
    assign count = count_r;

endmodule

// File: rtl/fta_req_queue32.sv
// Request queue and one-at-a-time issue sequencer in front of the FTA-to-WISHBONE bridge.
// Forwards matching/IRQ responses and synthesises an error response on read timeout.
module fta_req_queue32
    import fta_bus_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int WR_GAP  = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  fta_cmd_request32_t  req_i,
    output logic                full_o,
    output fta_cmd_request32_t  req_o,
    input  fta_cmd_response32_t resp_i,
    output fta_cmd_response32_t resp_o,
    output logic                busy_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2,
        WAIT_GAP = 2'd3
    } state_t;

    localparam int          CW         = $clog2(DEPTH) + 1;
    localparam logic [7:0]  TIMEOUT_C  = 8'(TIMEOUT);
    localparam logic [7:0]  GAP_LAST_C = 8'(WR_GAP - 1);
    localparam bit          GAP_EN     = (WR_GAP != 0);

    state_t              state_r;
    state_t              state_next_s;
    logic                tout_pend_r;
    logic                pend_next_s;
    fta_cmd_request32_t  hold_r;
    logic [7:0]          timer_r;
    logic [7:0]          gap_r;
    fta_cmd_response32_t resp_r;
    fta_cmd_response32_t resp_next_s;
    fta_cmd_response32_t tout_resp_s;
    fta_cmd_request32_t  req_s;
    logic                busy_r;
    logic                busy_next_s;

    fta_cmd_request32_t  head_s;
    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic [CW-1:0]       fifo_count_s;
    logic                pop_s;
    logic                push_ok_s;
    logic                irq_s;
    logic                match_s;
    logic                timeout_s;

    fta_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (req_i.cyc),
        .din   (req_i),
        .pop   (pop_s),
        .dout  (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Response classification and the synthetic timeout response.
    always_comb begin
        irq_s     = resp_i.ack && (resp_i.err == IRQ);
        match_s   = resp_i.ack && !irq_s && (resp_i.tid == hold_r.tid);
        timeout_s = (timer_r == TIMEOUT_C);
        push_ok_s = req_i.cyc && !fifo_full_s;
        tout_resp_s     = '0;
        tout_resp_s.ack = 1'b1;
        tout_resp_s.err = ERR;
        tout_resp_s.pri = hold_r.pri;
        tout_resp_s.tid = hold_r.tid;
        tout_resp_s.adr = hold_r.adr;
    end

    // FSM state register, including the deferred-timeout flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            tout_pend_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            tout_pend_r <= pend_next_s;
        end
    end

    // FSM next-state logic; an IRQ colliding with a timeout defers the timeout one cycle.
    always_comb begin
        state_next_s = state_r;
        pend_next_s  = tout_pend_r;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s) begin
                    state_next_s = ISSUE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ISSUE: begin
                if (needs_resp(hold_r)) begin
                    state_next_s = WAIT_RSP;
                end else if (GAP_EN) begin
                    state_next_s = WAIT_GAP;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WAIT_RSP: begin
                if (tout_pend_r) begin
                    if (!irq_s) begin
                        state_next_s = IDLE;
                        pend_next_s  = 1'b0;
                    end else begin
                        state_next_s = WAIT_RSP;
                    end
                end else if (match_s) begin
                    state_next_s = IDLE;
                end else if (timeout_s) begin
                    if (irq_s) begin
                        pend_next_s = 1'b1;
                    end else begin
                        state_next_s = IDLE;
                    end
                end else begin
                    state_next_s = WAIT_RSP;
                end
            end
            WAIT_GAP: begin
                if (gap_r == GAP_LAST_C) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = WAIT_GAP;
                end
            end
            default: begin
                state_next_s = IDLE;
                pend_next_s  = 1'b0;
            end
        endcase
    end

    // FSM outputs: queue pop, issue pulse, response mux and next busy flag.
    always_comb begin
        pop_s       = (state_r == IDLE) && !fifo_empty_s;
        req_s       = '0;
        resp_next_s = '0;
        if (state_r == ISSUE) begin
            req_s = hold_r;
        end else begin
            req_s = '0;
        end
        if (irq_s) begin
            resp_next_s = resp_i;
        end else if ((state_r == WAIT_RSP) && tout_pend_r) begin
            resp_next_s = tout_resp_s;
        end else if ((state_r == WAIT_RSP) && match_s) begin
            resp_next_s = resp_i;
        end else if ((state_r == WAIT_RSP) && timeout_s) begin
            resp_next_s = tout_resp_s;
        end else begin
            resp_next_s = '0;
        end
        busy_next_s = (state_next_s != IDLE) || push_ok_s ||
                      (fifo_count_s > CW'(1)) ||
                      ((fifo_count_s == CW'(1)) && !pop_s);
    end

    // Hold register, response timer, write-gap counter and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_r  <= '0;
            timer_r <= 8'd0;
            gap_r   <= 8'd0;
            resp_r  <= '0;
            busy_r  <= 1'b0;
        end else begin
            if (pop_s) begin
                hold_r     <= head_s;
                hold_r.cyc <= 1'b1;
            end
            if (state_next_s == ISSUE) begin
                timer_r <= 8'd0;
            end else if (((state_r == ISSUE) || (state_r == WAIT_RSP)) && !timeout_s) begin
                timer_r <= timer_r + 8'd1;
            end
            if (state_r != WAIT_GAP) begin
                gap_r <= 8'd0;
            end else begin
                gap_r <= gap_r + 8'd1;
            end
            resp_r <= resp_next_s;
            busy_r <= busy_next_s;
        end
    end

    assign req_o  = req_s;
    assign resp_o = resp_r;
    assign full_o = fifo_full_s;
    assign busy_o = busy_r;

endmodule

// File: tb/tb_fta_req_queue32.sv
// Directed self-checking bench for fta_req_queue32 (DEPTH=8, WR_GAP=4, TIMEOUT=255).
module tb_fta_req_queue32;
    import fta_bus_pkg::*;

    logic                clk;
    logic                rst;
    fta_cmd_request32_t  req_i;
    logic                full_o;
    fta_cmd_request32_t  req_o;
    fta_cmd_response32_t resp_i;
    fta_cmd_response32_t resp_o;
    logic                busy_o;

    int checks  = 0;
    int passed  = 0;
    int fails   = 0;
    int cyc_cnt = 0;
    int ack_cnt = 0;
    fta_cmd_request32_t iss_q[$];
    int                 iss_t[$];

    fta_req_queue32 #(.DEPTH(8), .WR_GAP(4), .TIMEOUT(255)) dut (
        .clk    (clk),
        .rst    (rst),
        .req_i  (req_i),
        .full_o (full_o),
        .req_o  (req_o),
        .resp_i (resp_i),
        .resp_o (resp_o),
        .busy_o (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Record every issue pulse and every response ack seen by the master.
    always @(negedge clk) begin
        if (req_o.cyc) begin
            iss_q.push_back(req_o);
            iss_t.push_back(cyc_cnt);
        end
        if (resp_o.ack) ack_cnt <= ack_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic fta_cmd_request32_t mk_req(input logic we, input logic [7:0] tid,
                                                  input logic [31:0] adr, input logic [31:0] dat);
        fta_cmd_request32_t r;
        r     = '0;
        r.cyc = 1'b1;
        r.we  = we;
        r.cti = CLASSIC;
        r.sel = 4'hF;
        r.tid = tid;
        r.adr = adr;
        r.dat = dat;
        return r;
    endfunction

    function automatic fta_cmd_response32_t mk_resp(input fta_err_t e, input logic [7:0] tid,
                                                    input logic [31:0] adr, input logic [31:0] dat);
        fta_cmd_response32_t r;
        r     = '0;
        r.ack = 1'b1;
        r.err = e;
        r.tid = tid;
        r.adr = adr;
        r.dat = dat;
        return r;
    endfunction

    // Present a request and hold it until an edge where full_o was low.
    task automatic enq(input fta_cmd_request32_t r);
        logic f;
        logic acc;
        acc   = 1'b0;
        req_i = r;
        for (int i = 0; i < 40 && !acc; i++) begin
            f = full_o;
            @(posedge clk);
            @(negedge clk);
            acc = !f;
        end
        chk("enq_accept", 64'(acc), 64'd1);
    endtask

    task automatic wait_issue(output int t);
        logic found;
        found = 1'b0;
        t     = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (req_o.cyc) begin
                found = 1'b1;
                t     = cyc_cnt;
            end else begin
                @(negedge clk);
            end
        end
        chk("issue_seen", 64'(found), 64'd1);
    endtask

    initial begin
        int t0;
        int tn;
        int a0;

        // 1: reset held with a request pending
        rst    = 1'b0;
        req_i  = mk_req(1'b0, 8'h01, 32'h0, 32'h0);
        resp_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_resp_ack", 64'(resp_o.ack), 64'd0);
        chk("rst_req_cyc",  64'(req_o.cyc),  64'd0);
        chk("rst_full",     64'(full_o),     64'd0);
        chk("rst_busy",     64'(busy_o),     64'd0);
        req_i = '0;
        rst   = 1'b1;
        repeat (2) @(negedge clk);

        // 2: single read with a stray mismatched-tid response first
        iss_q.delete(); iss_t.delete();
        enq(mk_req(1'b0, 8'h05, 32'h0000_1000, 32'h0));
        t0    = cyc_cnt;
        req_i = '0;
        wait_issue(tn);
        chk("rd_issue_lat", 64'(tn - t0), 64'd1);
        chk("rd_issue_adr", 64'(req_o.adr), 64'h1000);
        chk("rd_issue_tid", 64'(req_o.tid), 64'h05);
        repeat (2) @(negedge clk);
        resp_i = mk_resp(OKAY, 8'h06, 32'h0000_1000, 32'hBAD0_BAD0);
        @(negedge clk);
        resp_i = mk_resp(OKAY, 8'h05, 32'h0000_1000, 32'hCAFE_F00D);
        chk("rd_mismatch_drop", 64'(resp_o.ack), 64'd0);
        @(negedge clk);
        resp_i = '0;
        chk("rd_resp_ack", 64'(resp_o.ack), 64'd1);
        chk("rd_resp_dat", 64'(resp_o.dat), 64'hCAFE_F00D);
        chk("rd_resp_tid", 64'(resp_o.tid), 64'h05);
        chk("rd_resp_err", 64'(resp_o.err), 64'(OKAY));
        @(negedge clk);
        chk("rd_resp_one", 64'(resp_o.ack), 64'd0);
        repeat (5) @(negedge clk);
        chk("rd_one_pulse", 64'(iss_q.size()), 64'd1);
        chk("rd_idle_busy", 64'(busy_o), 64'd0);

        // 3: three back-to-back plain writes, 6-cycle issue spacing, no responses
        iss_q.delete(); iss_t.delete();
        a0 = ack_cnt;
        enq(mk_req(1'b1, 8'h11, 32'h0000_2000, 32'h1111_1111));
        enq(mk_req(1'b1, 8'h12, 32'h0000_2004, 32'h2222_2222));
        enq(mk_req(1'b1, 8'h13, 32'h0000_2008, 32'h3333_3333));
        req_i = '0;
        repeat (25) @(negedge clk);
        chk("wr_pulses", 64'(iss_q.size()), 64'd3);
        if (iss_t.size() == 3) begin
            chk("wr_gap_1", 64'(iss_t[1] - iss_t[0]), 64'd6);
            chk("wr_gap_2", 64'(iss_t[2] - iss_t[1]), 64'd6);
            chk("wr_order", 64'({iss_q[0].tid, iss_q[1].tid, iss_q[2].tid}), 64'h111213);
            chk("wr_dat",   64'(iss_q[1].dat), 64'h2222_2222);
        end
        chk("wr_no_ack", 64'(ack_cnt - a0), 64'd0);

        // 4: stalled read in hold, eight writes fill the queue, a further write is held
        iss_q.delete(); iss_t.delete();
        enq(mk_req(1'b0, 8'h20, 32'h0000_3000, 32'h0));
        for (int k = 1; k <= 8; k++) begin
            enq(mk_req(1'b1, 8'(8'h20 + k), 32'h0000_3000 + 32'(k * 4), 32'(k)));
            if (k == 7) chk("full_at_7", 64'(full_o), 64'd0);
        end
        chk("full_at_8", 64'(full_o), 64'd1);
        req_i = mk_req(1'b1, 8'h29, 32'h0000_3024, 32'd9);
        repeat (3) @(negedge clk);
        chk("full_held", 64'(full_o), 64'd1);
        chk("stall_issues", 64'(iss_q.size()), 64'd1);
        resp_i = mk_resp(OKAY, 8'h20, 32'h0000_3000, 32'h55AA_55AA);
        @(negedge clk);
        resp_i = '0;
        chk("stall_rd_resp", 64'({resp_o.ack, resp_o.tid}), 64'h120);
        enq(mk_req(1'b1, 8'h29, 32'h0000_3024, 32'd9));
        req_i = '0;
        repeat (90) @(negedge clk);
        chk("full_all_issued", 64'(iss_q.size()), 64'd10);
        if (iss_q.size() == 10) begin
            for (int i = 0; i < 10; i++) chk("full_order", 64'(iss_q[i].tid), 64'(8'h20 + i));
        end
        chk("full_drained", 64'(full_o), 64'd0);
        chk("full_idle", 64'(busy_o), 64'd0);

        // 5: read timeout, then a late ack must be dropped
        enq(mk_req(1'b0, 8'h07, 32'h0000_7000, 32'h0));
        req_i = '0;
        wait_issue(tn);
        repeat (255) @(negedge clk);
        chk("to_not_early", 64'(resp_o.ack), 64'd0);
        @(negedge clk);
        chk("to_latency", 64'(cyc_cnt - tn), 64'd256);
        chk("to_ack", 64'(resp_o.ack), 64'd1);
        chk("to_err", 64'(resp_o.err), 64'(ERR));
        chk("to_tid", 64'(resp_o.tid), 64'h07);
        chk("to_adr_dat", 64'({resp_o.adr, resp_o.dat}), 64'h0000_7000_0000_0000);
        resp_i = mk_resp(OKAY, 8'h07, 32'h0000_7000, 32'hDEAD_BEEF);
        @(negedge clk);
        resp_i = '0;
        chk("late_ack_drop", 64'(resp_o.ack), 64'd0);

        // 6: IRQ in the timeout cycle wins; timeout error follows one cycle later
        enq(mk_req(1'b0, 8'h09, 32'h0000_9000, 32'h0));
        req_i = '0;
        wait_issue(tn);
        repeat (255) @(negedge clk);
        resp_i = mk_resp(IRQ, 8'h33, 32'h0, 32'h0000_1234);
        @(negedge clk);
        resp_i = '0;
        chk("col_irq", 64'({resp_o.ack, resp_o.err, resp_o.dat}), {29'd0, 1'b1, IRQ, 32'h0000_1234});
        chk("col_busy", 64'(busy_o), 64'd1);
        @(negedge clk);
        chk("col_err", 64'({resp_o.ack, resp_o.err, resp_o.tid}), {53'd0, 1'b1, ERR, 8'h09});
        @(negedge clk);
        chk("col_done", 64'({resp_o.ack, busy_o}), 64'd0);

        // IRQ while idle is still forwarded
        resp_i = mk_resp(IRQ, 8'h44, 32'h0, 32'h0000_ABCD);
        @(negedge clk);
        resp_i = '0;
        chk("idle_irq", 64'({resp_o.ack, resp_o.err, resp_o.dat}), {29'd0, 1'b1, IRQ, 32'h0000_ABCD});

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
